argmax_stream_unit: RTL and testbench

Streaming, handshaked classifier decision block, the next-generation argmax for the SNN output path. Accepts a potential vector as `LANES` signed elements per beat over `BEATS = ceil(VEC_LEN/LANES)` beats and tracks the running maximum and runner-up. It returns winner index, winner value, runner-up index, the confidence margin and a framing-error flag. It sits between the SNN output layer and the result/host interface, and applies back-pressure in both directions.

---
 rtl/argmax_stream_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_argmax_stream_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_stream_unit.sv
// argmax_stream_unit
//
// Streaming argmax for a classifier output vector. A vector of VEC_LEN
// signed potentials arrives as BEATS = ceil(VEC_LEN/LANES) beats of LANES
// elements each. The block tracks the running maximum and runner-up and
// then presents a single registered result.
//
// Handshake semantics (both sides): a transfer happens on a rising clock
// edge where valid && ready are both high. A producer holds valid and its
// payload stable until that edge. i_ready and o_valid are pure decodes of
// the registered state, so neither depends combinationally on any input.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_valid / i_ready   input beat handshake
//   i_data              LANES signed elements, lane k = [(k+1)*DATA_W-1 -: DATA_W]
//   i_last              producer marks the final beat of a vector
//   o_valid / o_ready   result handshake, result held until accepted
//   o_class             winner index (lowest index wins ties)
//   o_max               winner value, signed
//   o_second            runner-up index (equals o_class if only one element)
//   o_margin            o_max - runner-up value, DATA_W+1 bits, never negative
//   o_err               framing error (i_last early or missing)
module argmax_stream_unit #(
    parameter int VEC_LEN = 3,
    parameter int DATA_W  = 48,
    parameter int LANES   = 1,
    localparam int IDX_W  = ($clog2(VEC_LEN) > 1) ? $clog2(VEC_LEN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [LANES*DATA_W-1:0] i_data,
    input  logic                    i_last,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [IDX_W-1:0]        o_class,
    output logic [DATA_W-1:0]       o_max,
    output logic [IDX_W-1:0]        o_second,
    output logic [DATA_W:0]         o_margin,
    output logic                    o_err
);

    localparam int BEATS = (VEC_LEN + LANES - 1) / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [0:0] {
        SCAN = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Registered state
    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      have_q, have_d;       // at least one element seen
    logic signed [DATA_W-1:0]  max_q, max_d;
    logic [IDX_W-1:0]          max_idx_q, max_idx_d;
    logic signed [DATA_W-1:0]  sec_q, sec_d;
    logic [IDX_W-1:0]          sec_idx_q, sec_idx_d;
    logic                      sec_set_q, sec_set_d;  // runner-up holds a real element

    logic [IDX_W-1:0]          o_class_q, o_class_d;
    logic [DATA_W-1:0]         o_max_q, o_max_d;
    logic [IDX_W-1:0]          o_second_q, o_second_d;
    logic [DATA_W:0]           o_margin_q, o_margin_d;
    logic                      o_err_q, o_err_d;

    // Compare chain results after folding in the current beat
    logic                      c_have;
    logic signed [DATA_W-1:0]  c_max;
    logic [IDX_W-1:0]          c_max_idx;
    logic signed [DATA_W-1:0]  c_sec;
    logic [IDX_W-1:0]          c_sec_idx;
    logic                      c_sec_set;
    logic signed [DATA_W-1:0]  elem;
    int                        elem_idx;

    logic                      accept;
    logic                      at_last_beat;
    logic                      vec_end;
    logic [IDX_W-1:0]          r_second;
    logic [DATA_W:0]           r_margin;

    assign i_ready  = (state_q == SCAN);
    assign o_valid  = (state_q == HOLD);
    assign o_class  = o_class_q;
    assign o_max    = o_max_q;
    assign o_second = o_second_q;
    assign o_margin = o_margin_q;
    assign o_err    = o_err_q;

    assign accept       = i_valid && (state_q == SCAN);
    assign at_last_beat = (cnt_q == LAST_BEAT);
    assign vec_end      = accept && (i_last || at_last_beat);

    // Lanes are folded in ascending element order. A strict '>' against the
    // max keeps the earliest index on ties; an equal later element lands in
    // the runner-up slot, giving a zero margin.
    always_comb begin
        c_have    = have_q;
        c_max     = max_q;
        c_max_idx = max_idx_q;
        c_sec     = sec_q;
        c_sec_idx = sec_idx_q;
        c_sec_set = sec_set_q;
        elem      = '0;
        elem_idx  = 0;
        for (int k = 0; k < LANES; k++) begin
            elem_idx = int'(cnt_q) * LANES + k;
            elem     = i_data[(k+1)*DATA_W-1 -: DATA_W];
            // Lanes past the end of the vector on a partial last beat are ignored
            if (elem_idx < VEC_LEN) begin
                if (!c_have) begin
                    c_have    = 1'b1;
                    c_max     = elem;
                    c_max_idx = IDX_W'(elem_idx);
                end else if (elem > c_max) begin
                    c_sec     = c_max;
                    c_sec_idx = c_max_idx;
                    c_sec_set = 1'b1;
                    c_max     = elem;
                    c_max_idx = IDX_W'(elem_idx);
                end else if (!c_sec_set || (elem > c_sec)) begin
                    c_sec     = elem;
                    c_sec_idx = IDX_W'(elem_idx);
                    c_sec_set = 1'b1;
                end
            end
        end
    end

    // Sign-extending both operands to DATA_W+1 bits makes the difference
    // exact; max >= second, so the result is always non-negative.
    always_comb begin
        r_second = c_max_idx;
        r_margin = '0;
        if (c_sec_set) begin
            r_second = c_sec_idx;
            r_margin = {c_max[DATA_W-1], c_max} - {c_sec[DATA_W-1], c_sec};
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        have_d     = have_q;
        max_d      = max_q;
        max_idx_d  = max_idx_q;
        sec_d      = sec_q;
        sec_idx_d  = sec_idx_q;
        sec_set_d  = sec_set_q;
        o_class_d  = o_class_q;
        o_max_d    = o_max_q;
        o_second_d = o_second_q;
        o_margin_d = o_margin_q;
        o_err_d    = o_err_q;

        case (state_q)
            SCAN: begin
                if (accept) begin
                    if (vec_end) begin
                        state_d    = HOLD;
                        cnt_d      = '0;
                        have_d     = 1'b0;
                        max_d      = '0;
                        max_idx_d  = '0;
                        sec_d      = '0;
                        sec_idx_d  = '0;
                        sec_set_d  = 1'b0;
                        o_class_d  = c_max_idx;
                        o_max_d    = c_max;
                        o_second_d = r_second;
                        o_margin_d = r_margin;
                        // i_last must coincide exactly with the final beat
                        o_err_d    = (i_last != at_last_beat);
                    end else begin
                        cnt_d     = cnt_q + 1'b1;
                        have_d    = c_have;
                        max_d     = c_max;
                        max_idx_d = c_max_idx;
                        sec_d     = c_sec;
                        sec_idx_d = c_sec_idx;
                        sec_set_d = c_sec_set;
                    end
                end
            end
            HOLD: begin
                if (o_ready) begin
                    state_d = SCAN;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SCAN;
            cnt_q      <= '0;
            have_q     <= 1'b0;
            max_q      <= '0;
            max_idx_q  <= '0;
            sec_q      <= '0;
            sec_idx_q  <= '0;
            sec_set_q  <= 1'b0;
            o_class_q  <= '0;
            o_max_q    <= '0;
            o_second_q <= '0;
            o_margin_q <= '0;
            o_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            have_q     <= have_d;
            max_q      <= max_d;
            max_idx_q  <= max_idx_d;
            sec_q      <= sec_d;
            sec_idx_q  <= sec_idx_d;
            sec_set_q  <= sec_set_d;
            o_class_q  <= o_class_d;
            o_max_q    <= o_max_d;
            o_second_q <= o_second_d;
            o_margin_q <= o_margin_d;
            o_err_q    <= o_err_d;
        end
    end

endmodule

// File: tb/tb_argmax_stream_unit.sv
// Bench for argmax_stream_unit. Two instances share clock and reset:
//   dut_a: VEC_LEN=3, LANES=1 (one element per beat)
//   dut_b: VEC_LEN=5, LANES=2 (partial, masked last beat)
// Inputs change on the falling edge; o_ready changes 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_argmax_stream_unit;

    localparam int DW = 48;
    localparam int RW = 1 + (DW + 1) + 3 + DW + 3;

    typedef struct packed {
        logic          err;
        logic [DW:0]   margin;
        logic [2:0]    sec;
        logic [DW-1:0] mx;
        logic [2:0]    cls;
    } res_t;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // dut_a signals
    logic          a_i_valid, a_i_ready, a_i_last, a_o_valid, a_o_err;
    logic          a_o_ready = 1'b1;
    logic [DW-1:0] a_i_data, a_o_max;
    logic [1:0]    a_o_class, a_o_second;
    logic [DW:0]   a_o_margin;

    // dut_b signals
    logic            b_i_valid, b_i_ready, b_i_last, b_o_valid, b_o_err;
    logic            b_o_ready = 1'b1;
    logic [2*DW-1:0] b_i_data;
    logic [DW-1:0]   b_o_max;
    logic [2:0]      b_o_class, b_o_second;
    logic [DW:0]     b_o_margin;

    argmax_stream_unit #(.VEC_LEN(3), .DATA_W(DW), .LANES(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_valid(a_i_valid), .i_ready(a_i_ready), .i_data(a_i_data), .i_last(a_i_last),
        .o_valid(a_o_valid), .o_ready(a_o_ready), .o_class(a_o_class), .o_max(a_o_max),
        .o_second(a_o_second), .o_margin(a_o_margin), .o_err(a_o_err)
    );

    argmax_stream_unit #(.VEC_LEN(5), .DATA_W(DW), .LANES(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_valid(b_i_valid), .i_ready(b_i_ready), .i_data(b_i_data), .i_last(b_i_last),
        .o_valid(b_o_valid), .o_ready(b_o_ready), .o_class(b_o_class), .o_max(b_o_max),
        .o_second(b_o_second), .o_margin(b_o_margin), .o_err(b_o_err)
    );

    // Scoreboard
    logic [RW-1:0] a_exp_q[$];
    logic [RW-1:0] b_exp_q[$];
    res_t          a_r, b_r;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // o_ready drivers (single process per signal)
    bit a_rand_rdy = 1'b0, b_rand_rdy = 1'b0;
    bit a_rdy_force = 1'b1, b_rdy_force = 1'b1;
    always @(posedge clk) begin
        #1;
        a_o_ready = a_rand_rdy ? ($urandom_range(0, 3) != 0) : a_rdy_force;
        b_o_ready = b_rand_rdy ? ($urandom_range(0, 3) != 0) : b_rdy_force;
    end

    // Result monitors: a result is taken on the next rising edge
    always @(negedge clk) begin
        if (rst_n && a_o_valid && a_o_ready) begin
            if (a_exp_q.size() == 0) begin
                check("a_unexpected_result", 64'(a_o_valid), 64'(0));
            end else begin
                a_r = a_exp_q.pop_front();
                check("a_class",  64'(a_o_class),  64'(a_r.cls));
                check("a_max",    64'(a_o_max),    64'(a_r.mx));
                check("a_second", 64'(a_o_second), 64'(a_r.sec));
                check("a_margin", 64'(a_o_margin), 64'(a_r.margin));
                check("a_err",    64'(a_o_err),    64'(a_r.err));
            end
        end
        if (rst_n && b_o_valid && b_o_ready) begin
            if (b_exp_q.size() == 0) begin
                check("b_unexpected_result", 64'(b_o_valid), 64'(0));
            end else begin
                b_r = b_exp_q.pop_front();
                check("b_class",  64'(b_o_class),  64'(b_r.cls));
                check("b_max",    64'(b_o_max),    64'(b_r.mx));
                check("b_second", 64'(b_o_second), 64'(b_r.sec));
                check("b_margin", 64'(b_o_margin), 64'(b_r.margin));
                check("b_err",    64'(b_o_err),    64'(b_r.err));
            end
        end
    end

    function automatic logic [6*DW-1:0] pack6(input logic [DW-1:0] e0, e1, e2, e3, e4, e5);
        return {e5, e4, e3, e2, e1, e0};
    endfunction

    function automatic logic [DW-1:0] rnd_el();
        int sel;
        sel = int'($urandom_range(0, 3));
        case (sel)
            0:       return DW'(int'($urandom_range(0, 8)) - 4);
            1:       return DW'({$urandom(), $urandom()});
            2:       return {1'b0, {(DW-1){1'b1}}};
            default: return {1'b1, {(DW-1){1'b0}}};
        endcase
    endfunction

    // Reference model: scan the first n elements in order
    function automatic res_t model(input logic [6*DW-1:0] ev, input int n, input logic err);
        res_t r;
        logic signed [DW-1:0] mx, sc, e;
        int ci, si;
        bit sset;
        mx = '0; sc = '0; ci = 0; si = 0; sset = 1'b0;
        for (int i = 0; i < n; i++) begin
            e = ev[i*DW +: DW];
            if (i == 0) begin
                mx = e; ci = 0;
            end else if (e > mx) begin
                sc = mx; si = ci; sset = 1'b1; mx = e; ci = i;
            end else if (!sset || e > sc) begin
                sc = e; si = i; sset = 1'b1;
            end
        end
        if (!sset) begin
            sc = mx; si = ci;
        end
        r.cls    = 3'(ci);
        r.mx     = mx;
        r.sec    = 3'(si);
        r.margin = {mx[DW-1], mx} - {sc[DW-1], sc};
        r.err    = err;
        return r;
    endfunction

    task automatic push_a(input int cls, input logic [DW-1:0] mx, input int sec,
                          input logic [DW:0] margin, input logic err);
        res_t r;
        r.cls = 3'(cls); r.mx = mx; r.sec = 3'(sec); r.margin = margin; r.err = err;
        a_exp_q.push_back(r);
    endtask

    task automatic push_b(input int cls, input logic [DW-1:0] mx, input int sec,
                          input logic [DW:0] margin, input logic err);
        res_t r;
        r.cls = 3'(cls); r.mx = mx; r.sec = 3'(sec); r.margin = margin; r.err = err;
        b_exp_q.push_back(r);
    endtask

    // Driver tasks: called at a falling edge, return at a falling edge
    task automatic beat_a(input logic [DW-1:0] d, input logic last);
        int t;
        t = 0;
        a_i_valid = 1'b1; a_i_data = d; a_i_last = last;
        while (!a_i_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!a_i_ready) check("a_beat_ready_timeout", 64'(a_i_ready), 64'(1));
        @(negedge clk);
        a_i_valid = 1'b0; a_i_last = 1'b0;
    endtask

    task automatic beat_b(input logic [2*DW-1:0] d, input logic last);
        int t;
        t = 0;
        b_i_valid = 1'b1; b_i_data = d; b_i_last = last;
        while (!b_i_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!b_i_ready) check("b_beat_ready_timeout", 64'(b_i_ready), 64'(1));
        @(negedge clk);
        b_i_valid = 1'b0; b_i_last = 1'b0;
    endtask

    task automatic send_vec_a(input logic [DW-1:0] e0, e1, e2, input int nb,
                              input int last_at, input bit gaps);
        logic [DW-1:0] e[3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        for (int b = 0; b < nb; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            beat_a(e[b], (b == last_at));
        end
    endtask

    task automatic send_vec_b(input logic [6*DW-1:0] ev, input int nb,
                              input int last_at, input bit gaps);
        for (int b = 0; b < nb; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            beat_b(ev[b*2*DW +: 2*DW], (b == last_at));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((a_exp_q.size() != 0 || b_exp_q.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("a_drain", 64'(a_exp_q.size()), 64'(0));
        check("b_drain", 64'(b_exp_q.size()), 64'(0));
    endtask

    localparam logic [DW-1:0] MAXS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MINS = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW:0]   FULL_MARGIN = {1'b0, {DW{1'b1}}};

    logic [6*DW-1:0] ev;
    int mode, nb, la, nel;

    initial begin
        rst_n = 1'b0;
        a_i_valid = 1'b0; a_i_data = '0; a_i_last = 1'b0;
        b_i_valid = 1'b0; b_i_data = '0; b_i_last = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_i_ready",  64'(a_i_ready),  64'(1));
        check("rst_o_valid",  64'(a_o_valid),  64'(0));
        check("rst_o_class",  64'(a_o_class),  64'(0));
        check("rst_o_max",    64'(a_o_max),    64'(0));
        check("rst_o_second", 64'(a_o_second), 64'(0));
        check("rst_o_margin", 64'(a_o_margin), 64'(0));
        check("rst_o_err",    64'(a_o_err),    64'(0));
        check("rst_b_i_ready", 64'(b_i_ready), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Basic vector, latency and throughput
        push_a(2, DW'(9), 0, (DW+1)'(4), 1'b0);
        send_vec_a(DW'(5), DW'(-2), DW'(9), 3, 2, 1'b0);
        check("lat_o_valid", 64'(a_o_valid), 64'(1));
        check("lat_i_ready", 64'(a_i_ready), 64'(0));
        @(negedge clk);
        check("thr_i_ready", 64'(a_i_ready), 64'(1));
        check("thr_o_valid", 64'(a_o_valid), 64'(0));

        // Ties, all negative, margin extremes
        push_a(0, DW'(7), 1, '0, 1'b0);
        send_vec_a(DW'(7), DW'(7), DW'(-1), 3, 2, 1'b0);
        push_a(1, DW'(-3), 2, '0, 1'b0);
        send_vec_a(DW'(-10), DW'(-3), DW'(-3), 3, 2, 1'b0);
        push_a(1, MAXS, 0, FULL_MARGIN, 1'b0);
        send_vec_a(MINS, MAXS, MINS, 3, 2, 1'b0);

        // Framing errors: single element, early last, missing last
        push_a(0, DW'(6), 0, '0, 1'b1);
        send_vec_a(DW'(6), DW'(0), DW'(0), 1, 0, 1'b0);
        push_a(1, DW'(9), 0, (DW+1)'(5), 1'b1);
        send_vec_a(DW'(4), DW'(9), DW'(0), 2, 1, 1'b0);
        push_a(2, DW'(3), 1, (DW+1)'(1), 1'b1);
        send_vec_a(DW'(1), DW'(2), DW'(3), 3, -1, 1'b0);

        // Two lanes with a masked lane on the last beat, then an early last
        push_b(2, DW'(8), 1, (DW+1)'(4), 1'b0);
        send_vec_b(pack6(DW'(1), DW'(4), DW'(8), DW'(2), DW'(3), DW'(100)), 3, 2, 1'b0);
        push_b(2, DW'(8), 1, (DW+1)'(4), 1'b1);
        send_vec_b(pack6(DW'(1), DW'(4), DW'(8), DW'(2), DW'(3), DW'(100)), 2, 1, 1'b0);
        drain();

        // Back-pressure: result held for 10 cycles
        a_rdy_force = 1'b0;
        @(negedge clk);
        push_a(0, DW'(3), 2, (DW+1)'(1), 1'b0);
        send_vec_a(DW'(3), DW'(-1), DW'(2), 3, 2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("bp_o_valid",  64'(a_o_valid),  64'(1));
            check("bp_i_ready",  64'(a_i_ready),  64'(0));
            check("bp_o_class",  64'(a_o_class),  64'(0));
            check("bp_o_max",    64'(a_o_max),    64'(3));
            check("bp_o_margin", 64'(a_o_margin), 64'(1));
            @(negedge clk);
        end
        a_rdy_force = 1'b1;
        drain();

        // Reset while holding a result
        a_rdy_force = 1'b0;
        @(negedge clk);
        send_vec_a(DW'(1), DW'(2), DW'(3), 3, 2, 1'b0);
        check("hold_o_valid", 64'(a_o_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("hrst_o_valid",  64'(a_o_valid),  64'(0));
        check("hrst_i_ready",  64'(a_i_ready),  64'(1));
        check("hrst_o_class",  64'(a_o_class),  64'(0));
        check("hrst_o_max",    64'(a_o_max),    64'(0));
        check("hrst_o_second", 64'(a_o_second), 64'(0));
        check("hrst_o_margin", 64'(a_o_margin), 64'(0));
        check("hrst_o_err",    64'(a_o_err),    64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        a_rdy_force = 1'b1;
        @(negedge clk);

        // Reset mid-vector, then a fresh vector
        beat_a(DW'(100), 1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_a(1, DW'(12), 2, '0, 1'b0);
        send_vec_a(DW'(-5), DW'(12), DW'(12), 3, 2, 1'b0);
        drain();

        // Random vectors with random back-pressure and input gaps
        a_rand_rdy = 1'b1;
        b_rand_rdy = 1'b1;
        for (int v = 0; v < 25; v++) begin
            ev   = pack6(rnd_el(), rnd_el(), rnd_el(), '0, '0, '0);
            mode = int'($urandom_range(0, 3));
            if (mode < 2) begin nb = 3; la = 2; end
            else if (mode == 2) begin nb = 3; la = -1; end
            else begin nb = int'($urandom_range(1, 2)); la = nb - 1; end
            a_exp_q.push_back(model(ev, nb, (mode >= 2)));
            send_vec_a(ev[0 +: DW], ev[DW +: DW], ev[2*DW +: DW], nb, la, 1'b1);
        end
        for (int v = 0; v < 25; v++) begin
            ev   = pack6(rnd_el(), rnd_el(), rnd_el(), rnd_el(), rnd_el(), rnd_el());
            mode = int'($urandom_range(0, 3));
            if (mode < 2) begin nb = 3; la = 2; end
            else if (mode == 2) begin nb = 3; la = -1; end
            else begin nb = int'($urandom_range(1, 2)); la = nb - 1; end
            nel = (nb * 2 < 5) ? nb * 2 : 5;
            b_exp_q.push_back(model(ev, nel, (mode >= 2)));
            send_vec_b(ev, nb, la, 1'b1);
        end
        a_rand_rdy = 1'b0;
        b_rand_rdy = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
